// File: rtl/axis_chk_pkg.sv
// -----------------------------------------------------------------------------
// axis_chk_pkg
// Shared definitions for the AXI-Stream frame checker:
//   - ready_mode encodings
//   - bit positions inside err_flags
//   - checker FSM state encoding
//   - PRBS33 next-state helper used by the ready generator
// -----------------------------------------------------------------------------
package axis_chk_pkg;

    // ready_mode encodings
    localparam logic [1:0] MODE_ALWAYS      = 2'd0;
    localparam logic [1:0] MODE_RANDOM      = 2'd1;
    localparam logic [1:0] MODE_AFTER_VALID = 2'd2;
    localparam logic [1:0] MODE_HOLD        = 2'd3;

    // err_flags = {timeout, early_eol, no_eol, unexp_sof, no_sof}
    localparam int ERR_W         = 5;
    localparam int ERR_NO_SOF    = 0;
    localparam int ERR_UNEXP_SOF = 1;
    localparam int ERR_NO_EOL    = 2;
    localparam int ERR_EARLY_EOL = 3;
    localparam int ERR_TIMEOUT   = 4;

    typedef enum logic {
        ST_WAIT_SOF = 1'b0,
        ST_IN_FRAME = 1'b1
    } chk_state_e;

    // PRBS33 step: shift left, feed back the XNOR of taps 32 and 19.
    function automatic logic [32:0] prbs33_next(input logic [32:0] s);
        return {s[31:0], s[32] ^ ~s[19]};
    endfunction

endpackage

// File: rtl/axis_ready_gen.sv
// -----------------------------------------------------------------------------
// axis_ready_gen
// Produces the registered s_tready for the frame checker.
//   clk        clock
//   rst        asynchronous reset, active-high
//   mode_i     ready_mode (ALWAYS / RANDOM / AFTER_VALID / HOLD)
//   tvalid_i   stream valid (used by AFTER_VALID)
//   tready_o   registered ready
// The PRBS33 advances every cycle regardless of mode, so the RANDOM pattern
// is a fixed function of the cycle count since reset.
// -----------------------------------------------------------------------------
module axis_ready_gen
    import axis_chk_pkg::*;
#(
    parameter logic [32:0] PRBS_SEED = 33'h04A4B_B532
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode_i,
    input  logic       tvalid_i,
    output logic       tready_o
);

    logic [32:0] prbs_q;
    logic        tready_q;
    logic        tready_d;

    always_comb begin
        tready_d = 1'b0;
        case (mode_i)
            MODE_ALWAYS:      tready_d = 1'b1;
            MODE_RANDOM:      tready_d = prbs_q[32];
            // Toggle off after every ready cycle: at most one beat per two cycles.
            MODE_AFTER_VALID: tready_d = tvalid_i & ~tready_q;
            default:          tready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prbs_q   <= PRBS_SEED;
            tready_q <= 1'b0;
        end else begin
            prbs_q   <= prbs33_next(prbs_q);
            tready_q <= tready_d;
        end
    end

    assign tready_o = tready_q;

endmodule

// File: rtl/axis_frame_checker.sv
// -----------------------------------------------------------------------------
// axis_frame_checker
// Synthesizable AXI-Stream video sink: generates s_tready, checks SOF (tuser)
// and EOL (tlast) framing against X_SIZE x Y_SIZE, counts words/lines/frames
// and keeps sticky error flags plus a valid-timeout flag.
//   clk, rst            clock, asynchronous active-high reset
//   s_tdata/s_tvalid/s_tready/s_tuser/s_tlast   AXI-Stream sink
//   ready_mode          0 ALWAYS, 1 RANDOM, 2 AFTER_VALID, 3 HOLD
//   err_clear           clears sticky flags (a simultaneous new error wins)
//   err_flags           {timeout, early_eol, no_eol, unexp_sof, no_sof}
//   x_count/y_count     next expected word / line index
//   frame_count         completed frames (wraps)
//   frame_done          one-cycle pulse after the final beat of a frame
// Optional build macro AXIS_FRAME_SUM_EN adds output frame_sum: the modulo
// 2^DATA_W sum of the tdata words of the last completed frame.
// -----------------------------------------------------------------------------
module axis_frame_checker
    import axis_chk_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          X_SIZE    = 480,
    parameter int          Y_SIZE    = 480,
    parameter int          TIMEOUT   = 100000,
    parameter int          CNT_W     = 16,
    parameter logic [32:0] PRBS_SEED = 33'h04A4B_B532
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tuser,
    input  logic              s_tlast,
    input  logic [1:0]        ready_mode,
    input  logic              err_clear,
    output logic [ERR_W-1:0]  err_flags,
    output logic [CNT_W-1:0]  x_count,
    output logic [CNT_W-1:0]  y_count,
    output logic [CNT_W-1:0]  frame_count,
    output logic              frame_done
`ifdef AXIS_FRAME_SUM_EN
    ,
    output logic [DATA_W-1:0] frame_sum
`endif
);

    localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(X_SIZE - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(Y_SIZE - 1);
    localparam int               TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    chk_state_e         state_q;
    logic [CNT_W-1:0]   x_q;
    logic [CNT_W-1:0]   y_q;
    logic [CNT_W-1:0]   frame_q;
    logic               frame_done_q;
    logic [ERR_W-1:0]   err_q;
    logic [TO_W-1:0]    idle_q;

    logic               beat;
    logic               accept;
    logic [CNT_W-1:0]   word_idx;
    logic [CNT_W-1:0]   line_idx;
    logic               at_x_last;
    logic               line_close;
    logic               frame_close;
    logic [ERR_W-1:0]   new_err;

    axis_ready_gen #(
        .PRBS_SEED (PRBS_SEED)
    ) u_ready_gen (
        .clk      (clk),
        .rst      (rst),
        .mode_i   (ready_mode),
        .tvalid_i (s_tvalid),
        .tready_o (s_tready)
    );

    // Beat decode. A tuser beat always restarts at word 0 of line 0, so the
    // index used for the line/frame decisions is forced to zero on SOF.
    always_comb begin
        beat        = s_tvalid & s_tready;
        accept      = beat & (s_tuser | (state_q == ST_IN_FRAME));
        word_idx    = s_tuser ? '0 : x_q;
        line_idx    = s_tuser ? '0 : y_q;
        at_x_last   = (word_idx == X_LAST);
        line_close  = accept & (at_x_last | s_tlast);
        frame_close = line_close & (line_idx == Y_LAST);

        new_err                = '0;
        new_err[ERR_NO_SOF]    = beat & ~s_tuser & (state_q == ST_WAIT_SOF);
        new_err[ERR_UNEXP_SOF] = beat & s_tuser & (state_q == ST_IN_FRAME);
        new_err[ERR_NO_EOL]    = accept & at_x_last & ~s_tlast;
        new_err[ERR_EARLY_EOL] = accept & ~at_x_last & s_tlast;
        new_err[ERR_TIMEOUT]   = ~s_tvalid & (idle_q == TO_LAST);
    end

    // Checker FSM, counters, flags and timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_WAIT_SOF;
            x_q          <= '0;
            y_q          <= '0;
            frame_q      <= '0;
            frame_done_q <= 1'b0;
            err_q        <= '0;
            idle_q       <= '0;
        end else begin
            frame_done_q <= frame_close;
            err_q        <= (err_clear ? '0 : err_q) | new_err;
            idle_q       <= (s_tvalid | new_err[ERR_TIMEOUT]) ? '0 : idle_q + TO_W'(1);

            if (accept) begin
                if (frame_close) begin
                    state_q <= ST_WAIT_SOF;
                    x_q     <= '0;
                    y_q     <= '0;
                    frame_q <= frame_q + CNT_W'(1);
                end else if (line_close) begin
                    state_q <= ST_IN_FRAME;
                    x_q     <= '0;
                    y_q     <= line_idx + CNT_W'(1);
                end else begin
                    state_q <= ST_IN_FRAME;
                    x_q     <= word_idx + CNT_W'(1);
                    y_q     <= line_idx;
                end
            end
        end
    end

    assign err_flags   = err_q;
    assign x_count     = x_q;
    assign y_count     = y_q;
    assign frame_count = frame_q;
    assign frame_done  = frame_done_q;

`ifdef AXIS_FRAME_SUM_EN
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] sum_d;
    logic [DATA_W-1:0] frame_sum_q;

    // Running sum including the current beat; an SOF beat starts a new sum.
    assign sum_d = (s_tuser ? '0 : sum_q) + s_tdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= '0;
            frame_sum_q <= '0;
        end else begin
            if (accept) begin
                sum_q <= sum_d;
            end
            if (frame_close) begin
                frame_sum_q <= sum_d;
            end
        end
    end

    assign frame_sum = frame_sum_q;
`else
    logic unused_tdata;
    assign unused_tdata = ^s_tdata;
`endif

endmodule
